// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: requester handshake, ALU drive/return and response bundle
interface alu_share_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int W = 32
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [4*NUM_REQ-1:0] req_ctl;
  logic [W*NUM_REQ-1:0] req_a;
  logic [W*NUM_REQ-1:0] req_b;
  logic [3:0]           alu_ctl;
  logic [W-1:0]         alu_a;
  logic [W-1:0]         alu_b;
  logic [W-1:0]         alu_out;
  logic                 alu_zero;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [NUM_REQ-1:0]   rsp_ready;
  logic [W-1:0]         rsp_data;
  logic                 rsp_zero;
  logic                 busy;
  modport slave (
    input  req_valid, req_ctl, req_a, req_b, alu_out, alu_zero, rsp_ready,
    output req_ready, alu_ctl, alu_a, alu_b, rsp_valid, rsp_data, rsp_zero, busy
  );
  modport master (
    output req_valid, req_ctl, req_a, req_b, alu_out, alu_zero, rsp_ready,
    input  req_ready, alu_ctl, alu_a, alu_b, rsp_valid, rsp_data, rsp_zero, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU among NUM_REQ requesters
module alu_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int W = 32
) (
  input logic clk,
  input logic reset,
  alu_share_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t r_state, w_next;
  logic [PW-1:0] r_ptr, r_grant, w_pick, w_idx;
  logic w_found, w_accept, w_release;
  logic [3:0] r_ctl;
  logic [W-1:0] r_a, r_b, r_data;
  logic r_zero;
  logic [3:0] w_ctl [NUM_REQ];
  logic [W-1:0] w_a [NUM_REQ];
  logic [W-1:0] w_b [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_split
    assign w_ctl[i] = bus.req_ctl[4*i +: 4];
    assign w_a[i]   = bus.req_a[W*i +: W];
    assign w_b[i]   = bus.req_b[W*i +: W];
  end
  // scan from the highest offset down so the lowest offset from r_ptr wins
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = PW'((int'(r_ptr) + k) % NUM_REQ);
      if (bus.req_valid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end
  assign w_accept      = (r_state == IDLE) && w_found && !reset;
  assign w_release     = (r_state == RESP) && bus.rsp_ready[r_grant];
  assign bus.req_ready = w_accept ? NUM_REQ'(1) << w_pick : '0;
  assign bus.rsp_valid = (r_state == RESP) ? NUM_REQ'(1) << r_grant : '0;
  assign bus.alu_ctl   = r_ctl;
  assign bus.alu_a     = r_a;
  assign bus.alu_b     = r_b;
  assign bus.rsp_data  = r_data;
  assign bus.rsp_zero  = r_zero;
  assign bus.busy      = r_state != IDLE;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (w_found ? EXEC : IDLE) :
             (r_state == EXEC) ? RESP : (w_release ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_ctl   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_data  <= '0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_ctl   <= w_ctl[w_pick];
        r_a     <= w_a[w_pick];
        r_b     <= w_b[w_pick];
        r_grant <= w_pick;
      end
      if (r_state == EXEC) begin
        r_data <= bus.alu_out;
        r_zero <= bus.alu_zero;
      end
      if (w_release) r_ptr <= (r_grant == PW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and randomized checks against a transaction-level model
module tb_alu_share_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  alu_share_arbiter_if #(.NUM_REQ(2), .W(32)) bus ();
  alu_share_arbiter #(.NUM_REQ(2), .W(32)) u_dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0;
  int errors = 0;
  int m_ptr = 0;
  logic [1:0] vmask = 2'b00;
  logic [1:0] rready = 2'b11;
  logic [3:0] ctl [2];
  logic [31:0] a [2];
  logic [31:0] b [2];
  function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    case (c)
      4'd0:    return x & y;
      4'd1:    return x | y;
      4'd2:    return x + y;
      4'd6:    return x - y;
      4'd7:    return (x < y) ? 32'd1 : 32'd0;
      4'd12:   return ~(x | y);
      default: return 32'd0;
    endcase
  endfunction
  assign bus.alu_out   = alu_ref(bus.alu_ctl, bus.alu_a, bus.alu_b);
  assign bus.alu_zero  = bus.alu_out == 32'd0;
  assign bus.req_valid = vmask;
  assign bus.req_ctl   = {ctl[1], ctl[0]};
  assign bus.req_a     = {a[1], a[0]};
  assign bus.req_b     = {b[1], b[0]};
  assign bus.rsp_ready = rready;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic int pick();
    for (int k = 0; k < 2; k++)
      if (vmask[(m_ptr + k) % 2]) return (m_ptr + k) % 2;
    return -1;
  endfunction
  function automatic logic [3:0] rand_op();
    logic [3:0] ops [6] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
    return ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : ops[$urandom_range(0, 5)];
  endfunction
  task automatic set_op(input int i, input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    ctl[i] = c;
    a[i] = x;
    b[i] = y;
  endtask
  // one full transaction; bp = cycles of withheld rsp_ready, keep = winner re-requests
  task automatic serve(input int bp, input bit keep);
    int p;
    logic [31:0] er, sa;
    logic [1:0] oh;
    #1;
    p = pick();
    oh = 2'b01 << p;
    er = alu_ref(ctl[p], a[p], b[p]);
    sa = a[p];
    check("accept_ready", 32'(bus.req_ready), 32'(oh));
    check("idle_busy", 32'(bus.busy), 32'd0);
    step();
    check("exec_busy", 32'(bus.busy), 32'd1);
    check("exec_ready", 32'(bus.req_ready), 32'd0);
    check("exec_alu_a", bus.alu_a, sa);
    if (keep) set_op(p, rand_op(), $urandom, $urandom);
    else vmask[p] = 1'b0;
    step();
    check("rsp_valid", 32'(bus.rsp_valid), 32'(oh));
    check("rsp_data", bus.rsp_data, er);
    check("rsp_zero", 32'(bus.rsp_zero), 32'(er == 32'd0));
    for (int n = 0; n < bp; n++) begin
      rready = ~oh;
      step();
      check("bp_valid", 32'(bus.rsp_valid), 32'(oh));
      check("bp_data", bus.rsp_data, er);
      check("bp_busy", 32'(bus.busy), 32'd1);
      check("bp_ready", 32'(bus.req_ready), 32'd0);
    end
    rready = 2'b11;
    step();
    m_ptr = (p + 1) % 2;
    check("release_busy", 32'(bus.busy), 32'd0);
    check("release_valid", 32'(bus.rsp_valid), 32'd0);
  endtask
  // abort an accepted op in EXEC (stage 0) or RESP (stage 1)
  task automatic abort(input int stage);
    int p;
    #1;
    p = pick();
    check("abort_accept", 32'(bus.req_ready), 32'(2'b01 << p));
    step();
    rready = 2'b00;
    if (stage == 1) begin
      step();
      check("abort_in_resp", 32'(bus.rsp_valid), 32'(2'b01 << p));
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    rready = 2'b11;
    m_ptr = 0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort_data", bus.rsp_data, 32'd0);
    check("abort_alu_a", bus.alu_a, 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    logic [1:0] nm;
    set_op(0, 4'd2, 32'd5, 32'd7);
    set_op(1, 4'd0, 32'd0, 32'd0);
    vmask = 2'b01;
    step();
    step();
    check("reset_ready", 32'(bus.req_ready), 32'd0);
    check("reset_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_data", bus.rsp_data, 32'd0);
    check("reset_zero", 32'(bus.rsp_zero), 32'd0);
    check("reset_ctl", 32'(bus.alu_ctl), 32'd0);
    reset = 1'b0;
    serve(0, 0);
    set_op(1, 4'd6, 32'h1234, 32'h1234);
    vmask = 2'b10;
    serve(0, 0);
    set_op(0, 4'd7, 32'd3, 32'd9);
    vmask = 2'b01;
    serve(0, 0);
    set_op(0, 4'd1, 32'hF0, 32'h0F);
    set_op(1, 4'd12, 32'h0, 32'h0);
    vmask = 2'b11;
    repeat (4) serve(0, 1);
    vmask = 2'b00;
    set_op(1, 4'd0, 32'hFF00FF00, 32'h0FF00FF0);
    vmask = 2'b10;
    serve(5, 0);
    set_op(0, 4'd15, 32'hFFFFFFFF, 32'd1);
    vmask = 2'b01;
    serve(0, 0);
    set_op(1, 4'd2, 32'hFFFFFFFF, 32'd1);
    vmask = 2'b10;
    serve(0, 0);
    set_op(0, 4'd2, 32'd1, 32'd1);
    vmask = 2'b01;
    serve(0, 0);
    set_op(0, 4'd2, 32'd10, 32'd20);
    set_op(1, 4'd2, 32'd30, 32'd40);
    vmask = 2'b11;
    abort(0);
    serve(0, 1);
    abort(1);
    serve(0, 0);
    vmask = 2'b00;
    for (int t = 0; t < 40; t++) begin
      nm = vmask | 2'($urandom_range(0, 3));
      if (nm == 2'b00) nm = 2'($urandom_range(1, 3));
      for (int i = 0; i < 2; i++)
        if (nm[i] && !vmask[i]) set_op(i, rand_op(), $urandom, ($urandom_range(0, 3) == 0) ? a[i] : $urandom);
      vmask = nm;
      serve($urandom_range(0, 2), $urandom_range(0, 1) == 1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
